pipe_ctrl: RTL and testbench

//  Central pipeline sequencer. Consumes hazard requests: load-use stall from the

---
 rtl/pipe_ctrl_pkg.sv | 65 ++++++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, hazard request priority
// and the per-stage enable/flush bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2,
        StHalted  = 2'd3
    } state_e;

    // Enumerator order encodes priority: lower value wins.
    typedef enum logic [2:0] {
        ReqHalt   = 3'd1,
        ReqMem    = 3'd2,
        ReqBranch = 3'd3,
        ReqStall  = 3'd4,
        ReqNone   = 3'd7
    } req_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CtrlOff = '0;

    localparam ctrl_t CtrlRun = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
    };

    // Everything upstream of WB holds; WB absorbs a bubble.
    localparam ctrl_t CtrlFreeze = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
        id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1, mem_wb_bubble: 1'b1
    };

    localparam ctrl_t CtrlFlush = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
    };

    // Hold PC and IF/ID, inject a NOP into EX.
    localparam ctrl_t CtrlStall = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
    };

    function automatic req_e decode_req(input logic halt, input logic mem_block,
                                        input logic br, input logic stall);
        if (halt)      return ReqHalt;
        if (mem_block) return ReqMem;
        if (br)        return ReqBranch;
        if (stall)     return ReqStall;
        return ReqNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard request / stage control bundle between the pipeline datapath and its
// sequencer.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             hdu_stall;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_ack;
    logic             halt_i;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_bubble;
    logic             halted;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output start, hdu_stall, br_taken, dmem_req, dmem_ack, halt_i,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_bubble, halted, err_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  start, hdu_stall, br_taken, dmem_req, dmem_ack, halt_i,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_bubble, halted, err_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates hazard requests into per-stage enables/flushes,
// tracks run/halt state and guards data-memory waits with a timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned    WaitW    = $clog2(TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             err_q, err_d;
    ctrl_t            ctrl;
    req_e             req;
    logic             mem_block;
    logic             stall_inc, flush_inc, wait_inc, wait_clr;
    logic [WaitW-1:0] wait_cnt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign mem_block = bus.dmem_req & ~bus.dmem_ack;
    assign req       = decode_req(bus.halt_i, mem_block, bus.br_taken, bus.hdu_stall);

    always_comb begin
        ctrl      = CtrlOff;
        state_d   = state_q;
        err_d     = err_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StRun;
            end
            StRun: begin
                ctrl     = CtrlRun;
                wait_clr = 1'b1;
                case (req)
                    ReqHalt: begin
                        ctrl    = CtrlOff;
                        state_d = StHalted;
                    end
                    ReqMem: begin
                        ctrl    = CtrlFreeze;
                        state_d = StMemWait;
                    end
                    ReqBranch: begin
                        ctrl      = CtrlFlush;
                        flush_inc = 1'b1;
                    end
                    ReqStall: begin
                        ctrl      = CtrlStall;
                        stall_inc = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMemWait: begin
                // Branch/stall/halt requests are not sampled here; upstream re-presents them.
                stall_inc = 1'b1;
                if (bus.dmem_ack) begin
                    ctrl     = CtrlRun;
                    wait_clr = 1'b1;
                    state_d  = StRun;
                end else begin
                    ctrl     = CtrlFreeze;
                    wait_inc = 1'b1;
                    if (wait_cnt == WaitLast) begin
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end
                end
            end
            StHalted: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc),
        .clr_i (1'b0),
        .q_o   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_inc),
        .clr_i (1'b0),
        .q_o   (flush_cnt)
    );

    sat_counter #(.W(WaitW)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .q_o   (wait_cnt)
    );

    assign bus.pc_en         = ctrl.pc_en;
    assign bus.if_id_en      = ctrl.if_id_en;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_en      = ctrl.id_ex_en;
    assign bus.id_ex_flush   = ctrl.id_ex_flush;
    assign bus.ex_mem_en     = ctrl.ex_mem_en;
    assign bus.mem_wb_en     = ctrl.mem_wb_en;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign bus.halted        = (state_q == StHalted);
    assign bus.err_timeout   = err_q;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one default instance and one with TIMEOUT=4, CNT_W=2.
module tb_pipe_ctrl;

    // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, bubble
    localparam logic [7:0] C_OFF    = 8'b0000_0000;
    localparam logic [7:0] C_RUN    = 8'b1101_0110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0011;
    localparam logic [7:0] C_FLUSH  = 8'b1111_1110;
    localparam logic [7:0] C_STALL  = 8'b0001_1110;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipe_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_ctrl_if #(.CNT_W(2))  bus_b ();

    pipe_ctrl #(.TIMEOUT(64), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.pc_en, bus_a.if_id_en, bus_a.if_id_flush, bus_a.id_ex_en,
                    bus_a.id_ex_flush, bus_a.ex_mem_en, bus_a.mem_wb_en, bus_a.mem_wb_bubble};
    assign ctl_b = {bus_b.pc_en, bus_b.if_id_en, bus_b.if_id_flush, bus_b.id_ex_en,
                    bus_b.id_ex_flush, bus_b.ex_mem_en, bus_b.mem_wb_en, bus_b.mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ctl_a !== C_OFF) begin n_err++;
            $display("FAIL rst_ctl: got %b want %b", ctl_a, C_OFF); end
        n_cmp++; if ({bus_a.halted, bus_a.err_timeout} !== 2'b00) begin n_err++;
            $display("FAIL rst_flags: got %b want 00", {bus_a.halted, bus_a.err_timeout}); end
        n_cmp++; if ({bus_a.stall_cnt, bus_a.flush_cnt} !== 32'd0) begin n_err++;
            $display("FAIL rst_cnts: got %h want 0", {bus_a.stall_cnt, bus_a.flush_cnt}); end
        rst_n = 1'b1;
        tick();
        bus_a.start = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_OFF) begin n_err++;
            $display("FAIL idle_ctl: got %b want %b", ctl_a, C_OFF); end
        tick();
        bus_a.start = 1'b0;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_err++;
            $display("FAIL run_ctl: got %b want %b", ctl_a, C_RUN); end
        n_cmp++; if (bus_a.halted !== 1'b0) begin n_err++;
            $display("FAIL run_halted: got %b want 0", bus_a.halted); end
    endtask

    task automatic test_stall();
        bus_a.hdu_stall = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_STALL) begin n_err++;
            $display("FAIL stall_ctl: got %b want %b", ctl_a, C_STALL); end
        tick();
        bus_a.hdu_stall = 1'b0;
        #1;
        n_cmp++; if (bus_a.stall_cnt !== 16'd1) begin n_err++;
            $display("FAIL stall_cnt: got %0d want 1", bus_a.stall_cnt); end
        n_cmp++; if (ctl_a !== C_RUN) begin n_err++;
            $display("FAIL stall_release: got %b want %b", ctl_a, C_RUN); end
    endtask

    task automatic test_branch_over_stall();
        bus_a.br_taken  = 1'b1;
        bus_a.hdu_stall = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_FLUSH) begin n_err++;
            $display("FAIL br_ctl: got %b want %b", ctl_a, C_FLUSH); end
        tick();
        bus_a.br_taken  = 1'b0;
        bus_a.hdu_stall = 1'b0;
        #1;
        n_cmp++; if (bus_a.flush_cnt !== 16'd1) begin n_err++;
            $display("FAIL br_flush_cnt: got %0d want 1", bus_a.flush_cnt); end
        n_cmp++; if (bus_a.stall_cnt !== 16'd1) begin n_err++;
            $display("FAIL br_stall_cnt: got %0d want 1", bus_a.stall_cnt); end
    endtask

    task automatic test_mem_wait();
        bus_a.dmem_req = 1'b1;
        bus_a.br_taken = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_FREEZE) begin n_err++;
            $display("FAIL mw_run_ctl: got %b want %b", ctl_a, C_FREEZE); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (ctl_a !== C_FREEZE) begin n_err++;
                $display("FAIL mw_hold_ctl[%0d]: got %b want %b", i, ctl_a, C_FREEZE); end
        end
        tick();
        bus_a.dmem_ack = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_err++;
            $display("FAIL mw_ack_ctl: got %b want %b", ctl_a, C_RUN); end
        n_cmp++; if (bus_a.stall_cnt !== 16'd3) begin n_err++;
            $display("FAIL mw_stall_cnt: got %0d want 3", bus_a.stall_cnt); end
        tick();
        bus_a.dmem_req = 1'b0;
        bus_a.dmem_ack = 1'b0;
        #1;
        n_cmp++; if (ctl_a !== C_FLUSH) begin n_err++;
            $display("FAIL mw_br_after: got %b want %b", ctl_a, C_FLUSH); end
        n_cmp++; if (bus_a.stall_cnt !== 16'd4) begin n_err++;
            $display("FAIL mw_stall_cnt_ack: got %0d want 4", bus_a.stall_cnt); end
        tick();
        bus_a.br_taken = 1'b0;
        #1;
        n_cmp++; if (bus_a.flush_cnt !== 16'd2) begin n_err++;
            $display("FAIL mw_flush_cnt: got %0d want 2", bus_a.flush_cnt); end
        n_cmp++; if (ctl_a !== C_RUN) begin n_err++;
            $display("FAIL mw_final_ctl: got %b want %b", ctl_a, C_RUN); end
    endtask

    task automatic test_timeout();
        bus_b.start = 1'b1;
        tick();
        bus_b.start    = 1'b0;
        bus_b.dmem_req = 1'b1;
        #1;
        n_cmp++; if (ctl_b !== C_FREEZE) begin n_err++;
            $display("FAIL to_run_ctl: got %b want %b", ctl_b, C_FREEZE); end
        repeat (4) tick();
        n_cmp++; if ({bus_b.halted, bus_b.err_timeout} !== 2'b00) begin n_err++;
            $display("FAIL to_last_wait: got %b want 00", {bus_b.halted, bus_b.err_timeout}); end
        n_cmp++; if (ctl_b !== C_FREEZE) begin n_err++;
            $display("FAIL to_last_ctl: got %b want %b", ctl_b, C_FREEZE); end
        tick();
        n_cmp++; if ({bus_b.halted, bus_b.err_timeout} !== 2'b11) begin n_err++;
            $display("FAIL to_halt: got %b want 11", {bus_b.halted, bus_b.err_timeout}); end
        n_cmp++; if (ctl_b !== C_OFF) begin n_err++;
            $display("FAIL to_halt_ctl: got %b want %b", ctl_b, C_OFF); end
        n_cmp++; if (bus_b.stall_cnt !== 2'd3) begin n_err++;
            $display("FAIL to_stall_sat: got %0d want 3", bus_b.stall_cnt); end
        bus_b.dmem_req = 1'b0;
        bus_b.start    = 1'b1;
        tick();
        bus_b.start = 1'b0;
        #1;
        n_cmp++; if ({bus_b.halted, ctl_b} !== {1'b1, C_OFF}) begin n_err++;
            $display("FAIL to_start_ignored: got %b want 1_%b", {bus_b.halted, ctl_b}, C_OFF); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus_b.halted, bus_b.err_timeout} !== 2'b00) begin n_err++;
            $display("FAIL to_rst_clear: got %b want 00", {bus_b.halted, bus_b.err_timeout}); end
        n_cmp++; if (bus_a.flush_cnt !== 16'd0 || ctl_a !== C_OFF) begin n_err++;
            $display("FAIL to_rst_a: got cnt %0d ctl %b want 0 %b", bus_a.flush_cnt, ctl_a, C_OFF); end
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_halt_sat();
        bus_b.start = 1'b1;
        tick();
        bus_b.start     = 1'b0;
        bus_b.hdu_stall = 1'b1;
        repeat (5) tick();
        bus_b.hdu_stall = 1'b0;
        #1;
        n_cmp++; if (bus_b.stall_cnt !== 2'd3) begin n_err++;
            $display("FAIL sat_stall_cnt: got %0d want 3", bus_b.stall_cnt); end
        n_cmp++; if (ctl_b !== C_RUN) begin n_err++;
            $display("FAIL sat_run_ctl: got %b want %b", ctl_b, C_RUN); end
        bus_b.halt_i = 1'b1;
        #1;
        n_cmp++; if ({bus_b.halted, ctl_b} !== {1'b0, C_OFF}) begin n_err++;
            $display("FAIL halt_cycle: got %b want 0_%b", {bus_b.halted, ctl_b}, C_OFF); end
        tick();
        bus_b.halt_i = 1'b0;
        #1;
        n_cmp++; if ({bus_b.halted, bus_b.err_timeout} !== 2'b10) begin n_err++;
            $display("FAIL halt_state: got %b want 10", {bus_b.halted, bus_b.err_timeout}); end
        n_cmp++; if (ctl_b !== C_OFF) begin n_err++;
            $display("FAIL halt_ctl: got %b want %b", ctl_b, C_OFF); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {bus_a.start, bus_a.hdu_stall, bus_a.br_taken, bus_a.dmem_req, bus_a.dmem_ack,
         bus_a.halt_i} = '0;
        {bus_b.start, bus_b.hdu_stall, bus_b.br_taken, bus_b.dmem_req, bus_b.dmem_ack,
         bus_b.halt_i} = '0;
        test_reset();
        test_stall();
        test_branch_over_stall();
        test_mem_wait();
        test_timeout();
        test_halt_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
